// File: rtl/tick_sched_pkg.sv
// Shared types and default sizing for the tick scheduler.
package tick_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DIV_W_DEF  = 8;
  localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One configuration request as carried by the handshake.
  typedef struct packed {
    logic [CH_W_DEF-1:0]  ch;
    logic [DIV_W_DEF-1:0] div;
    logic                 en;
  } cfg_t;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: period counter, divide/enable registers, tick strobe and phase square wave.
module tick_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  input  logic             zero,
  input  logic             load,
  input  logic [DIV_W-1:0] ld_div,
  input  logic             ld_en,
  output logic             tick,
  output logic             phase,
  output logic             en,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;

  // High on the edge that closes the current period.
  assign wrap = en && count && (cnt == div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      div   <= '0;
      en    <= 1'b0;
      tick  <= 1'b0;
      phase <= 1'b0;
    end else begin
      if (load) begin
        div <= ld_div;
        en  <= ld_en;
      end
      if (!count || zero) begin
        cnt   <= '0;
        tick  <= 1'b0;
        phase <= 1'b0;
      end else if (load) begin
        // A load on a running channel lands on its wrap: the closing tick still fires.
        cnt   <= '0;
        tick  <= wrap;
        phase <= ld_en & (phase ^ wrap);
      end else if (en) begin
        tick <= wrap;
        if (wrap) begin
          cnt   <= '0;
          phase <= ~phase;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end else begin
        cnt   <= '0;
        tick  <= 1'b0;
        phase <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable tick/phase scheduler: run FSM, single-entry config shadow and per-channel apply.
// Optional sync_in realignment input is built when TICK_SCHED_SYNC_EN is defined.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                      sys_clk,
  input  logic                      reset,
`ifdef TICK_SCHED_SYNC_EN
  input  logic                      sync_in,
`endif
  input  logic                      run,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic                      cfg_en,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         phase,
  output logic                      running
);

  localparam int CH_W = $clog2(NUM_CH);

  state_t state;
  state_t state_nxt;

  logic              count;
  logic              zero;
  logic              apply;
  logic              sh_full;
  logic [CH_W-1:0]   sh_ch;
  logic [DIV_W-1:0]  sh_div;
  logic              sh_en;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_wrap;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run)  state_nxt = RUN;
      RUN:     if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);
  // Channels advance only while in RUN with run still high; otherwise they are cleared.
  assign count   = (state == RUN) && run;

`ifdef TICK_SCHED_SYNC_EN
  logic sync_q;
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) sync_q <= 1'b0;
    else        sync_q <= sync_in;
  end
  assign zero = count && sync_in && !sync_q;
`else
  assign zero = 1'b0;
`endif

  // Handshake: a transfer happens on any edge where cfg_valid && cfg_ready; ready is
  // simply "shadow empty", so nothing is accepted on the edge that applies the shadow.
  assign cfg_ready = !sh_full;

  // Enabled, counting target waits for its own wrap; every other case applies at once.
  assign apply = sh_full && (!count || zero || !ch_en[sh_ch] || ch_wrap[sh_ch]);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sh_full <= 1'b0;
      sh_ch   <= '0;
      sh_div  <= '0;
      sh_en   <= 1'b0;
    end else if (apply) begin
      sh_full <= 1'b0;
    end else if (cfg_valid && !sh_full) begin
      sh_full <= 1'b1;
      sh_ch   <= cfg_ch;
      sh_div  <= cfg_div;
      sh_en   <= cfg_en;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_chan #(.DIV_W(DIV_W)) u_chan (
      .clk    (sys_clk),
      .reset  (reset),
      .count  (count),
      .zero   (zero),
      .load   (apply && (sh_ch == CH_W'(i))),
      .ld_div (sh_div),
      .ld_en  (sh_en),
      .tick   (tick[i]),
      .phase  (phase[i]),
      .en     (ch_en[i]),
      .wrap   (ch_wrap[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: cycle-exact expected vectors queued per cycle.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int W      = 2 * NUM_CH + 2;
  localparam logic [W-1:0] ALL_M   = '1;
  localparam logic [W-1:0] READY_M = W'(1) << (2 * NUM_CH);

  logic              sys_clk;
  logic              reset;
  logic              run;
  logic              sync_in;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_en;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] phase;
  logic              running;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int vectors;
  int miscompares;

  int                m_div [NUM_CH];
  logic [NUM_CH-1:0] m_en;

  tick_scheduler #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
`ifdef TICK_SCHED_SYNC_EN
    .sync_in   (sync_in),
`endif
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .tick      (tick),
    .phase     (phase),
    .running   (running)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] obs();
    return {running, cfg_ready, phase, tick};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected tick/phase for free-running enabled channels, k cycles after alignment.
  function automatic logic [W-1:0] std_vec(input int k, input logic rn, input logic rd);
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] ph;
    tk = '0;
    ph = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_en[i]) begin
        int p;
        p = m_div[i] + 1;
        tk[i] = (k > 0) && ((k % p) == 0);
        ph[i] = ((k / p) % 2) == 1;
      end
    end
    return {rn, rd, ph, tk};
  endfunction

  // Driver tasks
  task automatic set_cfg(input cfg_t c);
    cfg_ch  = c.ch;
    cfg_div = c.div;
    cfg_en  = c.en;
  endtask

  task automatic cyc(input string tag, input logic [W-1:0] e, input logic [W-1:0] m);
    logic [W-1:0] ee;
    logic [W-1:0] mm;
    exp_q.push_back(e);
    msk_q.push_back(m);
    @(posedge sys_clk);
    #1;
    ee = exp_q.pop_front();
    mm = msk_q.pop_front();
    check(tag, obs() & mm, ee & mm);
  endtask

  task automatic cfg_idle(input cfg_t c);
    set_cfg(c);
    cfg_valid = 1'b1;
    cyc("cfg_accept", '0, READY_M);
    cfg_valid = 1'b0;
    cyc("cfg_apply", READY_M, READY_M);
  endtask

  initial begin
    logic [W-1:0] e;
    logic [W-1:0] m;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    run         = 1'b0;
    sync_in     = 1'b0;
    cfg_valid   = 1'b0;
    cfg_ch      = '0;
    cfg_div     = '0;
    cfg_en      = 1'b0;
    m_en        = '0;
    for (int i = 0; i < NUM_CH; i++) m_div[i] = 0;

    #22;
    check("reset", obs(), READY_M);
    reset = 1'b1;
    @(posedge sys_clk);
    #1;
    cyc("idle", READY_M, ALL_M);

    // ch0 div=3 configured in IDLE, then run
    cfg_idle('{ch: 2'd0, div: 8'd3, en: 1'b1});
    m_en = 4'b0001;
    m_div[0] = 3;
    run = 1'b1;
    for (int k = 0; k <= 25; k++) cyc($sformatf("s1_k%0d", k), std_vec(k, 1'b1, 1'b1), ALL_M);

    // Retune ch0 to div=1 mid-period: current period completes, then spacing 2
    set_cfg('{ch: 2'd0, div: 8'd1, en: 1'b1});
    cfg_valid = 1'b1;
    for (int k = 26; k <= 45; k++) begin
      e = '0;
      e[2*NUM_CH+1] = 1'b1;
      if (k < 28) begin
        e[0] = 1'b0;
        e[NUM_CH] = ((k / 4) % 2) == 1;
      end else begin
        e[0] = ((k - 28) % 2) == 0;
        e[NUM_CH] = 1'b1 ^ (((k - 28) / 2) % 2 == 1);
      end
      e[2*NUM_CH] = (k >= 28 && k != 38);
      // ch1 div=0 requested after k=37; target disabled so it applies the next edge
      if (k >= 40) begin
        e[1] = 1'b1;
        e[NUM_CH+1] = ((k - 40) % 2) == 0;
      end
      cyc($sformatf("s2_k%0d", k), e, ALL_M);
      if (k == 26 || k == 38) cfg_valid = 1'b0;
      if (k == 37) begin
        set_cfg('{ch: 2'd1, div: 8'd0, en: 1'b1});
        cfg_valid = 1'b1;
      end
    end

    run = 1'b0;
    cyc("stop0", READY_M, ALL_M);
    cyc("stop1", READY_M, ALL_M);

    // Back-to-back requests with cfg_valid held: ch2, ch3, ch0
    set_cfg('{ch: 2'd2, div: 8'd2, en: 1'b1});
    cfg_valid = 1'b1;
    cyc("b2b_acc2", '0, ALL_M);
    set_cfg('{ch: 2'd3, div: 8'd5, en: 1'b1});
    cyc("b2b_app2", READY_M, ALL_M);
    cyc("b2b_acc3", '0, ALL_M);
    set_cfg('{ch: 2'd0, div: 8'd3, en: 1'b1});
    cyc("b2b_app3", READY_M, ALL_M);
    cyc("b2b_acc0", '0, ALL_M);
    cfg_valid = 1'b0;
    cyc("b2b_app0", READY_M, ALL_M);

    m_en = 4'b1111;
    m_div[0] = 3;
    m_div[1] = 0;
    m_div[2] = 2;
    m_div[3] = 5;
    run = 1'b1;
    for (int k = 0; k <= 13; k++) cyc($sformatf("s4_k%0d", k), std_vec(k, 1'b1, 1'b1), ALL_M);

    // Disable ch0 in RUN: one final tick at its wrap, then silent
    set_cfg('{ch: 2'd0, div: 8'd3, en: 1'b0});
    cfg_valid = 1'b1;
    for (int k = 14; k <= 27; k++) begin
      e = std_vec(k, 1'b1, k >= 16);
      m = ALL_M;
      e[0] = (k == 16);
      e[NUM_CH] = (k < 16) ? (((k / 4) % 2) == 1) : 1'b0;
      if (k == 16) m[NUM_CH] = 1'b0;
      cyc($sformatf("s5_k%0d", k), e, m);
      if (k == 14) cfg_valid = 1'b0;
    end

    // Asynchronous reset mid-run
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", obs(), READY_M);
    @(posedge sys_clk);
    #1;
    check("rst_hold", obs(), READY_M);
    reset = 1'b1;
    cyc("post_rst0", {1'b1, 1'b1, 8'h00}, ALL_M);
    cyc("post_rst1", {1'b1, 1'b1, 8'h00}, ALL_M);
    run = 1'b0;
    cyc("post_rst2", READY_M, ALL_M);

`ifdef TICK_SCHED_SYNC_EN
    cfg_idle('{ch: 2'd0, div: 8'd5, en: 1'b1});
    cfg_idle('{ch: 2'd1, div: 8'd2, en: 1'b1});
    m_en = 4'b0011;
    m_div[0] = 5;
    m_div[1] = 2;
    run = 1'b1;
    for (int k = 0; k <= 6; k++) cyc($sformatf("pre_sync_k%0d", k), std_vec(k, 1'b1, 1'b1), ALL_M);
    sync_in = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      cyc($sformatf("sync_k%0d", k), std_vec(k, 1'b1, 1'b1), ALL_M);
      sync_in = 1'b0;
    end
    run = 1'b0;
    cyc("sync_stop", READY_M, ALL_M);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
